rtype_issue: RTL
================

RTYPE_ISSUE -- requirements
Module: rtype_issue

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr_ready  out  1  block can accept an instruction.
REQ-006 instr  in  32  MIPS R-type word: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
REQ-007 alu_rs_data  out  32  first ALU operand, registered.
REQ-008 alu_rt_data  out  32  second ALU operand, registered.
REQ-009 alu_funct  out  6  ALU operation code, registered.
REQ-010 alu_shamt  out  5  ALU shift amount, registered.
REQ-011 alu_result  in  32  combinational result returned by the ALU.
REQ-012 done  out  1  one-cycle pulse: instruction retired.
REQ-013 illegal  out  1  one-cycle pulse: instruction rejected.
REQ-014 dbg_we  in  1  debug register write enable.
REQ-015 dbg_addr  in  5  debug register address.
REQ-016 dbg_wdata  in  32  debug write data.
REQ-017 dbg_rdata  out  32  combinational read of R[dbg_addr].

Function
REQ-018 The block SHALL contain a 32x32 register file; R0 SHALL always read 0 and SHALL ignore all writes.
REQ-019 The FSM SHALL have the states IDLE, DECODE, EXEC, WB, and ERR; instr_ready SHALL be 1 only in IDLE.
REQ-020 A handshake (instr_valid & instr_ready at edge T) SHALL latch instr and move the FSM to DECODE for cycle T+1; instr_valid without instr_ready SHALL be ignored.
REQ-021 DECODE SHALL be legal only for op=000000 with funct 100001 (ADDU), 100011 (SUBU), 000000 (SLL), or 000100 (SLLV); any other word SHALL go to ERR.
REQ-022 For a legal word, DECODE SHALL register the ALU outputs at the end of T+1 as follows:
- ADDU: funct=001001, rs_data=R[rs], rt_data=R[rt].
- SUBU: funct=001010, rs_data=R[rs], rt_data=R[rt].
- SLL: funct=100001, rs_data=R[rt], shamt=instr shamt.
- SLLV: funct=110101, rs_data=R[rt], rt_data={27'b0,R[rs][4:0]}.
- Unused operand fields: 0.
REQ-023 For ADDU/SUBU, alu_shamt SHALL be 0; instr shamt SHALL be ignored.
REQ-024 EXEC (cycle T+2) SHALL hold the ALU outputs stable and capture alu_result at the end of the cycle.
REQ-025 WB (cycle T+3) SHALL assert done=1 and write the captured result to R[rd] at the end of the cycle; rd=0 SHALL retire with done but no write.
REQ-026 ERR (cycle T+2) SHALL assert illegal=1, change no register, and return to IDLE; instr_ready SHALL be 1 again in T+3.
REQ-027 After WB, the FSM SHALL return to IDLE; instr_ready SHALL be 1 in T+4, giving a throughput of one instruction per 4 cycles.
REQ-028 Arithmetic SHALL be modulo 2^32 with no overflow flag; SUBU SHALL wrap (5-7 = 0xFFFFFFFE).
REQ-029 dbg_we SHALL write R[dbg_addr] only when the state is IDLE; it SHALL be ignored in any other state and for dbg_addr=0.
REQ-030 A debug write and an instruction handshake in the same IDLE cycle SHALL both take effect, and the instruction SHALL observe the written value.
REQ-031 The ALU outputs SHALL retain their last values outside DECODE updates.

Reset
REQ-032 While rst_n=0 at a clock edge, the following SHALL apply:
- state SHALL be IDLE.
- All 32 registers SHALL be 0.
- alu_rs_data, alu_rt_data, alu_funct, alu_shamt, done, and illegal SHALL be 0.
- instr_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-033 Reset in any state SHALL abort the instruction in flight, with no writeback and no done/illegal pulse.

Verification
REQ-034 Reset release -> instr_ready=1, alu_funct=0, dbg_rdata=0 for all dbg_addr, no done/illegal.
REQ-035 Debug write R1=7, R2=5, then instr=0x00221821 (ADDU r3,r1,r2) -> in T+2: alu_funct=001001, rs_data=7, rt_data=5; done in T+3; R3=12.
REQ-036 instr=0x00412023 (SUBU r4,r2,r1) -> alu_funct=001010; R4=0xFFFFFFFE.
REQ-037 Debug write R8=0x23, then instr=0x01013004 (SLLV r6,r1,r8) -> rs_data=7, rt_data=3, funct=110101; R6=56.
REQ-038 instr=0x20010005 -> illegal pulse in T+2, no done, registers unchanged, instr_ready=1 in T+3.
REQ-039 ADDU with rd=0 -> done pulses, R0 stays 0.
REQ-040 ADDU with rst_n=0 in EXEC -> no done, FSM in IDLE, all registers 0.

Source files
------------

// File: rtl/rtype_issue.sv
// Multi-cycle MIPS R-type issue stage with a 32x32 register file.
// Handles ADDU/SUBU/SLL/SLLV; other words raise a one-cycle illegal pulse.
module rtype_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_rs_data,
  output logic [31:0] alu_rt_data,
  output logic [5:0]  alu_funct,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  output logic        done,
  output logic        illegal,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] WB     = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  logic [2:0]  state;
  logic [31:0] ir;
  logic [31:0] res;
  logic [31:0] regs [32];

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] sh;
  logic [5:0] fn;

  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign sh = ir[10:6];
  assign fn = ir[5:0];

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign rs_val = regs[rs];
  assign rt_val = regs[rt];

  logic is_addu;
  logic is_subu;
  logic is_sll;
  logic is_sllv;
  logic legal;

  assign is_addu = (op == 6'd0) && (fn == 6'b100001);
  assign is_subu = (op == 6'd0) && (fn == 6'b100011);
  assign is_sll  = (op == 6'd0) && (fn == 6'b000000);
  assign is_sllv = (op == 6'd0) && (fn == 6'b000100);
  assign legal   = is_addu | is_subu | is_sll | is_sllv;

  logic [5:0]  d_fn;
  logic [31:0] d_a;
  logic [31:0] d_b;
  logic [4:0]  d_sh;

  // Translate the latched word into ALU operands and opcode
  always_comb begin
    d_fn = '0;
    d_a  = '0;
    d_b  = '0;
    d_sh = '0;
    unique case (1'b1)
      is_addu: begin
        d_fn = 6'b001001;
        d_a  = rs_val;
        d_b  = rt_val;
      end
      is_subu: begin
        d_fn = 6'b001010;
        d_a  = rs_val;
        d_b  = rt_val;
      end
      is_sll: begin
        d_fn = 6'b100001;
        d_a  = rt_val;
        d_sh = sh;
      end
      is_sllv: begin
        d_fn = 6'b110101;
        d_a  = rt_val;
        d_b  = {27'b0, rs_val[4:0]};
      end
      default: ;
    endcase
  end

  assign instr_ready = rst_n && (state == IDLE);
  assign done        = (state == WB);
  assign illegal     = (state == ERR);
  assign dbg_rdata   = regs[dbg_addr];

  // Sequencer: IDLE -> DECODE -> EXEC -> WB, or DECODE -> ERR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ir          <= '0;
      res         <= '0;
      alu_rs_data <= '0;
      alu_rt_data <= '0;
      alu_funct   <= '0;
      alu_shamt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (legal) begin
            alu_rs_data <= d_a;
            alu_rt_data <= d_b;
            alu_funct   <= d_fn;
            alu_shamt   <= d_sh;
            state       <= EXEC;
          end else begin
            state <= ERR;
          end
        end
        EXEC: begin
          res   <= alu_result;
          state <= WB;
        end
        WB:      state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Register file: debug port only while idle, writeback in WB; R0 stays 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (state == IDLE && dbg_we && dbg_addr != 5'd0)
        regs[dbg_addr] <= dbg_wdata;
      if (state == WB && rd != 5'd0)
        regs[rd] <= res;
    end
  end

endmodule
